// File: rtl/sigmacore_mem_arbiter.sv
// Arbitrates the SigmaCore unified memory port between fetch and load/store, one transaction at a time.
// Define SIGMA_ARB_RR_EN for round-robin on contention (default build: data has fixed priority).
module sigmacore_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                arb_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP_I,
    ST_RESP_D
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_err_q, d_err_d;
  logic                grant_data;
  logic                timed_out;

`ifdef SIGMA_ARB_RR_EN
  // Set when data won the most recent contended grant; only contention updates it.
  logic                last_win_data_q, last_win_data_d;
  assign grant_data = d_req && (!if_req || !last_win_data_q);
`else
  assign grant_data = d_req;
`endif

  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = '0;
    if_rdata_d = if_rdata_q;
    if_err_d   = if_err_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
`ifdef SIGMA_ARB_RR_EN
    last_win_data_d = last_win_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
`ifdef SIGMA_ARB_RR_EN
          if (if_req && d_req) begin
            last_win_data_d = grant_data;
          end
`endif
          if (grant_data) begin
            state_d = ST_BUSY_D;
            addr_d  = d_addr;
            we_d    = d_we;
            be_d    = d_be;
            wdata_d = d_wdata;
          end else begin
            state_d = ST_BUSY_I;
            addr_d  = if_addr;
            we_d    = 1'b0;
            be_d    = '1;
            wdata_d = '0;
          end
        end
      end

      ST_BUSY_I: begin
        // A ready on the final counted cycle still completes normally.
        if (mem_ready) begin
          if_rdata_d = mem_rdata;
          if_err_d   = 1'b0;
          state_d    = ST_RESP_I;
        end else if (timed_out) begin
          if_rdata_d = '0;
          if_err_d   = 1'b1;
          state_d    = ST_RESP_I;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BUSY_D: begin
        if (mem_ready) begin
          d_rdata_d = we_q ? '0 : mem_rdata;
          d_err_d   = 1'b0;
          state_d   = ST_RESP_D;
        end else if (timed_out) begin
          d_rdata_d = '0;
          d_err_d   = 1'b1;
          state_d   = ST_RESP_D;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP_I: state_d = ST_IDLE;
      ST_RESP_D: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
`ifdef SIGMA_ARB_RR_EN
      last_win_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
`ifdef SIGMA_ARB_RR_EN
      last_win_data_q <= last_win_data_d;
`endif
    end
  end

  // Handshake outputs decode straight from the state register so reset clears them at once.
  assign mem_req   = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign arb_busy  = (state_q != ST_IDLE);
  assign if_ack    = (state_q == ST_RESP_I);
  assign d_ack     = (state_q == ST_RESP_D);
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_sigmacore_mem_arbiter.sv
// Scoreboard bench for sigmacore_mem_arbiter: directed transactions, queued expectations, ack monitor.
// Build with SIGMA_ARB_RR_EN defined to check the round-robin grant order.
module tb_sigmacore_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int TIMEOUT = 16;
`ifdef SIGMA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [BE_W-1:0]   d_be = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              arb_busy;

  always #5 clk = ~clk;

  sigmacore_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_busy(arb_busy)
  );

  typedef struct { logic is_data; logic [31:0] rdata; logic err; } ack_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } mreq_t;

  ack_t  exp_ack_q[$];
  mreq_t exp_mem_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] rdata, input logic err);
    exp_mem_q.push_back('{1'b0, addr, 4'hF, 32'h0});
    exp_ack_q.push_back('{1'b0, rdata, err});
  endtask

  task automatic expect_data(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    exp_mem_q.push_back('{we, addr, be, wdata});
    exp_ack_q.push_back('{1'b1, rdata, err});
  endtask

  // ---------------- memory model ----------------
  // mode 0: ready after lat BUSY cycles; 1: never ready; 2: ready on BUSY cycle ready_at
  logic [31:0] mem_arr [logic [31:0]];
  int          mode = 0;
  int          lat = 1;
  int          ready_at = 16;
  bit          idle_pulse = 1'b0;
  bit          in_txn = 1'b0;
  bit          have_cur = 1'b0;
  int          cyc = 0;
  int          last_len = 0;
  mreq_t       cur;
  logic [31:0] wtmp;
  bit          fire;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mem_ready = 1'b0;
        if (in_txn) begin
          in_txn = 1'b0;
          last_len = cyc;
        end
      end else if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cyc = 0;
          if (exp_mem_q.size() == 0) begin
            have_cur = 1'b0;
            n_checks++;
            n_fail++;
            $display("FAIL mem_unexpected_req: addr 0x%08h, no request expected", mem_addr);
          end else begin
            have_cur = 1'b1;
            cur = exp_mem_q.pop_front();
          end
        end
        cyc++;
        if (have_cur) begin
          chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_be", {28'b0, mem_be}, {28'b0, cur.be});
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        fire = (mode == 0 && cyc == lat) || (mode == 2 && cyc == ready_at);
        if (fire) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            wtmp = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) wtmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem_arr[mem_addr] = wtmp;
            mem_rdata = 32'hDEADBEEF;
          end else begin
            mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'h0BAD0BAD;
        end
      end else begin
        if (in_txn) begin
          in_txn = 1'b0;
          last_len = cyc;
        end
        mem_ready = idle_pulse;
        mem_rdata = idle_pulse ? 32'h77777777 : 32'h0;
        idle_pulse = 1'b0;
      end
    end
  end

  // ---------------- ack monitor ----------------
  ack_t e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (if_ack || d_ack) begin
        chk("dual_ack", {31'b0, if_ack & d_ack}, 32'h0);
        chk("mem_req_during_ack", {31'b0, mem_req}, 32'h0);
        $display("txn %s ack rdata=0x%08h err=%0b t=%0t", d_ack ? "D" : "I",
                 d_ack ? d_rdata : if_rdata, d_ack ? d_err : if_err, $time);
        if (exp_ack_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: port %s, no ack expected", d_ack ? "D" : "I");
        end else begin
          e = exp_ack_q.pop_front();
          chk("ack_port_is_data", {31'b0, d_ack}, {31'b0, e.is_data});
          chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
          chk("ack_err", {31'b0, d_ack ? d_err : if_err}, {31'b0, e.err});
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic fetch_txn(input logic [31:0] addr);
    bit got = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = addr;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (if_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("if_ack_within_bound", {31'b0, got}, 32'h1);
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    bit got = 1'b0;
    @(negedge clk);
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_be = be;
    d_wdata = wdata;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (d_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("d_ack_within_bound", {31'b0, got}, 32'h1);
    @(negedge clk);
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    mem_arr[32'h0000_0000] = 32'h0000_0293;
    mem_arr[32'h0000_0300] = 32'h3333_3333;
    mem_arr[32'h0000_0304] = 32'h4444_4444;
    mem_arr[32'h0000_0500] = 32'h5555_5555;
    for (int r = 0; r < 3; r++) begin
      mem_arr[32'h100 + 4 * r] = 32'hA000_0000 + r;
      mem_arr[32'h200 + 4 * r] = 32'hB000_0000 + r;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_arb_busy", {31'b0, arb_busy}, 32'h0);
    chk("rst_acks", {30'b0, if_ack, d_ack}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_we_be", {27'b0, mem_we, mem_be}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single fetch, cycle-accurate latency
    mode = 0;
    lat = 1;
    expect_fetch(32'h0, 32'h0000_0293, 1'b0);
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0;
    chk("t1_no_mem_req_in_idle", {31'b0, mem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("t1_mem_req_next_cycle", {31'b0, mem_req}, 32'h1);
    chk("t1_busy", {31'b0, arb_busy}, 32'h1);
    @(posedge clk);
    #1;
    chk("t1_if_ack_cycle", {31'b0, if_ack}, 32'h1);
    @(negedge clk);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_idle_after_ack", {30'b0, arb_busy, if_ack}, 32'h0);

    // 2: store held for several cycles, then loads (incl. partial byte enables)
    lat = 3;
    expect_data(1'b1, 32'hCAFE_F00C, 4'hF, 32'h95FD_E100, 32'h0, 1'b0);
    data_txn(1'b1, 32'hCAFE_F00C, 4'hF, 32'h95FD_E100);
    expect_data(1'b0, 32'hCAFE_F00C, 4'hF, 32'h0, 32'h95FD_E100, 1'b0);
    data_txn(1'b0, 32'hCAFE_F00C, 4'hF, 32'h0);
    expect_data(1'b1, 32'hCAFE_F00C, 4'h3, 32'h1111_AAAA, 32'h0, 1'b0);
    data_txn(1'b1, 32'hCAFE_F00C, 4'h3, 32'h1111_AAAA);
    expect_data(1'b0, 32'hCAFE_F00C, 4'hF, 32'h0, 32'h95FD_AAAA, 1'b0);
    data_txn(1'b0, 32'hCAFE_F00C, 4'hF, 32'h0);
    lat = 1;

    // 3: simultaneous requests, three rounds
    for (int r = 0; r < 3; r++) begin
      if (!RR || r != 1) begin
        expect_data(1'b0, 32'h200 + 4 * r, 4'hF, 32'h0, 32'hB000_0000 + r, 1'b0);
        expect_fetch(32'h100 + 4 * r, 32'hA000_0000 + r, 1'b0);
      end else begin
        expect_fetch(32'h100 + 4 * r, 32'hA000_0000 + r, 1'b0);
        expect_data(1'b0, 32'h200 + 4 * r, 4'hF, 32'h0, 32'hB000_0000 + r, 1'b0);
      end
      fork
        fetch_txn(32'h100 + 4 * r);
        data_txn(1'b0, 32'h200 + 4 * r, 4'hF, 32'h0);
      join
    end

    // 4: timeouts on both ports, then normal completion
    mode = 1;
    expect_fetch(32'h300, 32'h0, 1'b1);
    fetch_txn(32'h300);
    @(posedge clk);
    chk("t4_fetch_busy_len", last_len, TIMEOUT);
    expect_data(1'b1, 32'h310, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
    data_txn(1'b1, 32'h310, 4'hF, 32'h1234_5678);
    @(posedge clk);
    chk("t4_data_busy_len", last_len, TIMEOUT);
    mode = 0;
    expect_fetch(32'h300, 32'h3333_3333, 1'b0);
    fetch_txn(32'h300);

    // 6: ready pulse in IDLE ignored; ready on the exact timeout cycle wins
    idle_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_pulse_ignored", {30'b0, arb_busy, mem_req}, 32'h0);
    mode = 2;
    ready_at = TIMEOUT;
    expect_data(1'b0, 32'h304, 4'hF, 32'h0, 32'h4444_4444, 1'b0);
    data_txn(1'b0, 32'h304, 4'hF, 32'h0);
    @(posedge clk);
    chk("t6_busy_len", last_len, TIMEOUT);
    mode = 0;

    // 5: asynchronous reset in the middle of BUSY_D, fetch pending
    mode = 1;
    exp_mem_q.push_back('{1'b0, 32'h400, 4'hF, 32'h0});
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h400;
    d_be = 4'hF;
    @(posedge clk);
    #1;
    chk("t5_mem_req_busy_d", {31'b0, mem_req}, 32'h1);
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h500;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("t5_rst_arb_busy", {31'b0, arb_busy}, 32'h0);
    chk("t5_rst_acks", {30'b0, if_ack, d_ack}, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    mode = 0;
    lat = 1;
    expect_fetch(32'h500, 32'h5555_5555, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk);
        #1;
        if (if_ack) begin
          got = 1'b1;
          break;
        end
      end
      chk("t5_pending_fetch_serviced", {31'b0, got}, 32'h1);
    end
    @(negedge clk);
    if_req = 1'b0;

    // drain
    for (int i = 0; i < 20; i++) begin
      if (exp_ack_q.size() == 0 && exp_mem_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_ack_queue", exp_ack_q.size(), 32'h0);
    chk("drain_mem_queue", exp_mem_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
